// File: rtl/mem_addr_station.sv
// Memory-op reservation station with address generation: holds loads/stores until their
// source pregs are ready, issues the oldest ready op and registers {rs1+imm, mem_idx, store data}.
module mem_addr_station #(
  parameter int NUM_ENTRIES = 8,
  parameter int PREG_BITS   = 6,
  parameter int MIDX_BITS   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  input  logic                 disp_is_store,
  input  logic [PREG_BITS-1:0] disp_ps1,
  input  logic                 disp_ps1_rdy,
  input  logic [PREG_BITS-1:0] disp_ps2,
  input  logic                 disp_ps2_rdy,
  input  logic [31:0]          disp_imm,
  input  logic [MIDX_BITS-1:0] disp_mem_idx,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [PREG_BITS-1:0] cdb_pd,
  output logic [PREG_BITS-1:0] rf_ps1,
  output logic [PREG_BITS-1:0] rf_ps2,
  input  logic [31:0]          rf_v1,
  input  logic [31:0]          rf_v2,
  output logic                 addr_valid,
  output logic [31:0]          addr,
  output logic [MIDX_BITS-1:0] mem_idx_out,
  output logic [31:0]          store_wdata
);
  localparam int IDX_BITS = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid, is_store, r1, r2;
  logic [PREG_BITS-1:0]   ps1     [NUM_ENTRIES];
  logic [PREG_BITS-1:0]   ps2     [NUM_ENTRIES];
  logic [31:0]            imm     [NUM_ENTRIES];
  logic [MIDX_BITS-1:0]   mem_idx [NUM_ENTRIES];
  // older[i][j] set means entry i was dispatched before entry j
  logic [NUM_ENTRIES-1:0] older   [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] ready, blocked, valid_next;
  logic                   sel_found, free_found, disp_ok, disp_r1, disp_r2;
  logic [IDX_BITS-1:0]    sel_idx, free_idx;

  always_comb begin
    ready   = valid & r1 & r2;
    blocked = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ready[i] && !blocked[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_BITS'(i);
      end
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_BITS'(i);
      end
    end
  end

  always_comb begin
    disp_ok = disp_valid && !full && free_found;
    disp_r1 = disp_ps1_rdy || (cdb_valid && cdb_pd == disp_ps1) || (disp_ps1 == '0);
    disp_r2 = !disp_is_store || disp_ps2_rdy || (cdb_valid && cdb_pd == disp_ps2) ||
              (disp_ps2 == '0);
    valid_next = valid;
    if (sel_found) valid_next[sel_idx] = 1'b0;
    if (disp_ok) valid_next[free_idx] = 1'b1;
    if (flush) valid_next = '0;
    rf_ps1 = sel_found ? ps1[sel_idx] : '0;
    rf_ps2 = sel_found ? ps2[sel_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      is_store <= '0;
      r1       <= '0;
      r2       <= '0;
      full     <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ps1[i]     <= '0;
        ps2[i]     <= '0;
        imm[i]     <= '0;
        mem_idx[i] <= '0;
        older[i]   <= '0;
      end
    end else begin
      valid <= valid_next;
      full  <= &valid_next;
      if (!flush) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (cdb_valid && valid[i]) begin
            if (ps1[i] == cdb_pd) r1[i] <= 1'b1;
            if (ps2[i] == cdb_pd) r2[i] <= 1'b1;
          end
        end
        if (disp_ok) begin
          is_store[free_idx] <= disp_is_store;
          ps1[free_idx]      <= disp_ps1;
          ps2[free_idx]      <= disp_ps2;
          r1[free_idx]       <= disp_r1;
          r2[free_idx]       <= disp_r2;
          imm[free_idx]      <= disp_imm;
          mem_idx[free_idx]  <= disp_mem_idx;
          older[free_idx]    <= '0;
          // every occupant (including one issuing now) is older than the newcomer
          for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (valid[j]) older[j][free_idx] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_valid  <= 1'b0;
      addr        <= '0;
      mem_idx_out <= '0;
      store_wdata <= '0;
    end else begin
      addr_valid <= sel_found && !flush;
      if (sel_found && !flush) begin
        addr        <= rf_v1 + imm[sel_idx];
        mem_idx_out <= mem_idx[sel_idx];
        store_wdata <= is_store[sel_idx] ? rf_v2 : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_addr_station.sv
// Bench for mem_addr_station: an age-ordered queue model predicts every issue and result;
// a monitor pops the expected results whenever the station presents addr_valid.
module tb_mem_addr_station;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0, disp_is_store = 1'b0, disp_ps1_rdy = 1'b0, disp_ps2_rdy = 1'b0;
  logic [5:0]  disp_ps1 = '0, disp_ps2 = '0, disp_mem_idx = '0;
  logic [31:0] disp_imm = '0;
  logic        full;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_pd = '0;
  logic [5:0]  rf_ps1, rf_ps2;
  logic [31:0] rf_v1, rf_v2;
  logic        addr_valid;
  logic [31:0] addr, store_wdata;
  logic [5:0]  mem_idx_out;

  logic [31:0] regval [64];
  assign rf_v1 = regval[rf_ps1];
  assign rf_v2 = regval[rf_ps2];

  mem_addr_station #(.NUM_ENTRIES(8), .PREG_BITS(6), .MIDX_BITS(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_is_store(disp_is_store),
    .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy),
    .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_imm(disp_imm), .disp_mem_idx(disp_mem_idx), .full(full),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .rf_ps1(rf_ps1), .rf_ps2(rf_ps2), .rf_v1(rf_v1), .rf_v2(rf_v2),
    .addr_valid(addr_valid), .addr(addr), .mem_idx_out(mem_idx_out),
    .store_wdata(store_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [5:0]  p1;
    logic        r1;
    logic [5:0]  p2;
    logic        r2;
    logic [31:0] imm;
    logic [5:0]  mi;
  } ent_t;

  typedef struct {
    logic [31:0] a;
    logic [5:0]  mi;
    logic [31:0] wd;
  } res_t;

  ent_t mq[$];   // station contents, oldest first
  res_t sb[$];   // expected results in order
  int   ncheck = 0;
  int   nerr = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst && addr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_addr_valid", 32'(addr_valid), 32'h0);
      end else begin
        res_t r;
        r = sb.pop_front();
        chk("addr", addr, r.a);
        chk("mem_idx_out", 32'(mem_idx_out), 32'(r.mi));
        chk("store_wdata", store_wdata, r.wd);
      end
    end
  end

  task automatic model_step();
    int   k;
    int   occ;
    ent_t e;
    res_t r;
    occ = mq.size();
    chk("full", 32'(full), 32'(occ == 8));
    k = -1;
    foreach (mq[i]) if (k < 0 && mq[i].r1 && mq[i].r2) k = i;
    chk("rf_ps1", 32'(rf_ps1), (k >= 0) ? 32'(mq[k].p1) : 32'h0);
    if (k >= 0 && mq[k].st) chk("rf_ps2", 32'(rf_ps2), 32'(mq[k].p2));
    if (flush) begin
      mq.delete();
      return;
    end
    if (k >= 0) begin
      r.a  = regval[mq[k].p1] + mq[k].imm;
      r.mi = mq[k].mi;
      r.wd = mq[k].st ? regval[mq[k].p2] : 32'h0;
      sb.push_back(r);
      mq.delete(k);
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (mq[i].p1 == cdb_pd) mq[i].r1 = 1'b1;
        if (mq[i].p2 == cdb_pd) mq[i].r2 = 1'b1;
      end
    end
    if (disp_valid && occ < 8) begin
      e.st  = disp_is_store;
      e.p1  = disp_ps1;
      e.p2  = disp_ps2;
      e.imm = disp_imm;
      e.mi  = disp_mem_idx;
      e.r1  = disp_ps1_rdy || (cdb_valid && cdb_pd == disp_ps1) || disp_ps1 == 6'd0;
      e.r2  = !disp_is_store || disp_ps2_rdy || (cdb_valid && cdb_pd == disp_ps2) ||
              disp_ps2 == 6'd0;
      mq.push_back(e);
    end
  endtask

  task automatic cycle(input logic dv, input logic st, input logic [5:0] p1, input logic p1r,
                       input logic [5:0] p2, input logic p2r, input logic [31:0] im,
                       input logic [5:0] mi, input logic cv, input logic [5:0] cpd,
                       input logic fl);
    @(posedge clk);
    #1;
    disp_valid = dv; disp_is_store = st; disp_ps1 = p1; disp_ps1_rdy = p1r;
    disp_ps2 = p2; disp_ps2_rdy = p2r; disp_imm = im; disp_mem_idx = mi;
    cdb_valid = cv; cdb_pd = cpd; flush = fl;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cdb(input logic [5:0] pd);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, pd, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    mq.delete();
    sb.delete();
    #1;
    chk("rst_addr_valid", 32'(addr_valid), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_mem_idx", 32'(mem_idx_out), 32'h0);
    chk("rst_wdata", store_wdata, 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_rf_ps1", 32'(rf_ps1), 32'h0);
    chk("rst_rf_ps2", 32'(rf_ps2), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) cdb(6'(i));
    for (int i = 0; i < 12; i++) idle();
    chk("drain_station", 32'(mq.size()), 32'h0);
    chk("drain_results", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regval[i] = $urandom;
    regval[0] = 32'h0;
    regval[5] = 32'h0000_1000;
    regval[3] = 32'hFFFF_FFFC;
    regval[4] = 32'h0000_0100;
    regval[7] = 32'h0000_2000;
    regval[9] = 32'hDEAD_BEEF;
    do_reset();

    // plain load, latency one cycle after issue
    cycle(1, 0, 6'd5, 1, 6'd0, 0, 32'd4, 6'd1, 0, 0, 0);
    idle();
    idle();
    chk("t1_valid", 32'(addr_valid), 32'h1);
    chk("t1_addr", addr, 32'h0000_1004);

    // address wrap in both directions
    cycle(1, 0, 6'd3, 1, 6'd0, 0, 32'd8, 6'd2, 0, 0, 0);
    cycle(1, 0, 6'd4, 1, 6'd0, 0, 32'hFFFF_FFF0, 6'd3, 0, 0, 0);
    idle();
    chk("t5_wrap_hi", addr, 32'h0000_0004);
    idle();
    chk("t5_wrap_lo", addr, 32'h0000_00F0);
    idle();

    // store waits for its data preg, woken by the CDB
    cycle(1, 1, 6'd7, 1, 6'd9, 0, 32'h10, 6'd4, 0, 0, 0);
    idle();
    chk("t2_not_issued", 32'(addr_valid), 32'h0);
    cdb(6'd9);
    idle();
    idle();
    chk("t2_valid", 32'(addr_valid), 32'h1);
    chk("t2_wdata", store_wdata, 32'hDEAD_BEEF);
    chk("t2_addr", addr, 32'h0000_2010);

    // two entries woken together issue oldest first
    cycle(1, 0, 6'd11, 0, 6'd0, 0, 32'd0, 6'd10, 0, 0, 0);
    cycle(1, 0, 6'd11, 0, 6'd0, 0, 32'd0, 6'd20, 0, 0, 0);
    cdb(6'd11);
    idle();
    idle();
    chk("t4_first", 32'(mem_idx_out), 32'd10);
    idle();
    chk("t4_second", 32'(mem_idx_out), 32'd20);
    idle();

    // fill the station, drop the ninth dispatch, then free one slot
    for (int i = 0; i < 8; i++) cycle(1, 0, 6'(8 + i), 0, 6'd0, 0, 32'(i), 6'(32 + i), 0, 0, 0);
    cycle(1, 0, 6'd0, 1, 6'd0, 0, 32'd0, 6'd63, 0, 0, 0);
    chk("t3_full", 32'(full), 32'h1);
    cdb(6'd8);
    idle();
    chk("t3_still_full", 32'(full), 32'h1);
    idle();
    chk("t3_full_drop", 32'(full), 32'h0);
    drain();

    // flush with three waiting entries and one in flight
    for (int i = 0; i < 3; i++) cycle(1, 0, 6'(12 + i), 0, 6'd0, 0, 32'd0, 6'(i), 0, 0, 0);
    cycle(1, 0, 6'd0, 1, 6'd0, 0, 32'd0, 6'd5, 0, 0, 0);
    cycle(0, 0, 6'd0, 0, 6'd0, 0, 32'd0, 6'd0, 0, 0, 1);
    idle();
    chk("t6_flush_full", 32'(full), 32'h0);
    cycle(1, 0, 6'd5, 1, 6'd0, 0, 32'd8, 6'd6, 0, 0, 0);
    drain();

    // same with reset arriving while the result is in flight
    for (int i = 0; i < 3; i++) cycle(1, 0, 6'(12 + i), 0, 6'd0, 0, 32'd0, 6'(i), 0, 0, 0);
    cycle(1, 0, 6'd0, 1, 6'd0, 0, 32'd0, 6'd5, 0, 0, 0);
    idle();
    do_reset();
    cycle(1, 1, 6'd5, 1, 6'd9, 1, 32'd12, 6'd7, 0, 0, 0);
    drain();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom % 3) != 0, ($urandom % 2) == 1, 6'($urandom_range(0, 15)),
            ($urandom % 4) == 0, 6'($urandom_range(0, 15)), ($urandom % 4) == 0,
            $urandom, 6'($urandom), ($urandom % 2) == 1, 6'($urandom_range(0, 15)),
            ($urandom % 60) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end
endmodule
